// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 mux (sel=1 picks A).
// Optional switch counter and preemption pulse are enabled by defining MUX_SEL_ARB_SWCNT_EN.
module mux_sel_arbiter #(
    parameter int HOLD_MIN = 2,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        done,
    output logic        grant_a,
    output logic        grant_b,
    output logic        sel,
    output logic        busy
`ifdef MUX_SEL_ARB_SWCNT_EN
    ,
    output logic [15:0] sw_cnt,
    output logic        preempt_pulse
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_MIN_C = CNT_W'(HOLD_MIN);
    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] TEN_SAT    = {CNT_W{1'b1}};

    state_e           state_q;
    logic [CNT_W-1:0] tenure_q;
    logic             done_pend_q;
    logic             ptr_q;          // 0: A wins the next tie, 1: B wins it
    logic             grant_a_q;
    logic             grant_b_q;
    logic             sel_q;
    logic             busy_q;

    logic in_grant, in_a, own_req, oth_req, held_min;
    logic release_w, preempt_w, early_w;
    logic go_a, go_b, go_idle;

    always_comb begin
        in_grant  = (state_q != IDLE);
        in_a      = (state_q == GNT_A);
        own_req   = in_a ? req_a : req_b;
        oth_req   = in_a ? req_b : req_a;
        held_min  = (tenure_q >= HOLD_MIN_C);
        release_w = in_grant & (done | ~own_req | done_pend_q) & held_min;
        preempt_w = in_grant & (MAX_HOLD != 0) & (tenure_q >= MAX_HOLD_C) & oth_req;
        early_w   = in_grant & (done | ~own_req) & ~held_min;
        go_a      = 1'b0;
        go_b      = 1'b0;
        go_idle   = 1'b0;
        if (!in_grant) begin
            go_a = req_a & (~req_b | ~ptr_q);
            go_b = req_b & ~go_a;
        end else begin
            // Handoff and forced preemption share one path, so both together cannot conflict.
            go_a    = (preempt_w | (release_w & oth_req)) & ~in_a;
            go_b    = (preempt_w | (release_w & oth_req)) & in_a;
            go_idle = release_w & ~oth_req;
        end
    end

`ifdef MUX_SEL_ARB_SWCNT_EN
    logic [15:0] sw_cnt_q;
    logic        preempt_pulse_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tenure_q    <= '0;
            done_pend_q <= 1'b0;
            ptr_q       <= 1'b0;
            grant_a_q   <= 1'b0;
            grant_b_q   <= 1'b0;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MUX_SEL_ARB_SWCNT_EN
            sw_cnt_q        <= '0;
            preempt_pulse_q <= 1'b0;
`endif
        end else begin
`ifdef MUX_SEL_ARB_SWCNT_EN
            preempt_pulse_q <= preempt_w;
`endif
            if (go_a) begin
                state_q     <= GNT_A;
                tenure_q    <= CNT_W'(1);
                done_pend_q <= 1'b0;
                ptr_q       <= 1'b1;
                grant_a_q   <= 1'b1;
                grant_b_q   <= 1'b0;
                sel_q       <= 1'b1;
                busy_q      <= 1'b1;
`ifdef MUX_SEL_ARB_SWCNT_EN
                if (!sel_q) sw_cnt_q <= sw_cnt_q + 16'd1;
`endif
            end else if (go_b) begin
                state_q     <= GNT_B;
                tenure_q    <= CNT_W'(1);
                done_pend_q <= 1'b0;
                ptr_q       <= 1'b0;
                grant_a_q   <= 1'b0;
                grant_b_q   <= 1'b1;
                sel_q       <= 1'b0;
                busy_q      <= 1'b1;
`ifdef MUX_SEL_ARB_SWCNT_EN
                if (sel_q) sw_cnt_q <= sw_cnt_q + 16'd1;
`endif
            end else if (go_idle) begin
                state_q     <= IDLE;
                tenure_q    <= '0;
                done_pend_q <= 1'b0;
                grant_a_q   <= 1'b0;
                grant_b_q   <= 1'b0;
                busy_q      <= 1'b0;
            end else if (in_grant) begin
                if (tenure_q != TEN_SAT) tenure_q <= tenure_q + CNT_W'(1);
                if (early_w) done_pend_q <= 1'b1;
            end
        end
    end

    assign grant_a = grant_a_q;
    assign grant_b = grant_b_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
`ifdef MUX_SEL_ARB_SWCNT_EN
    assign sw_cnt        = sw_cnt_q;
    assign preempt_pulse = preempt_pulse_q;
`endif

endmodule
